// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: pin-side and CPU-side signals of the switch debouncer.
// The slave side is the debouncer; the master side drives pins and acks.
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] switch_in;
  logic [WIDTH-1:0] switch_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic             change_ack;

  modport master (
    output switch_in,
    output change_ack,
    input  switch_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  switch_in,
    input  change_ack,
    output switch_out,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel 2-flop sync, prescaled saturating integrator,
// hysteresis output, rise/fall pulses and a sticky changed flag with ack.
module switch_debouncer #(
  parameter int WIDTH    = 8,
  parameter int CNT_BITS = 6,
  parameter int PRESCALE = 1
) (
  input logic               clock,
  input logic               reset,
  switch_debouncer_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_BITS-1:0] MAX = '1;
  localparam logic [CNT_BITS-1:0] MID =
    CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0]    s1;
  logic [WIDTH-1:0]    s2;
  logic [PW-1:0]       pcnt;
  logic                tick;
  logic [CNT_BITS-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]    out_q;
  logic [WIDTH-1:0]    out_nxt;
  logic [WIDTH-1:0]    rise_q;
  logic [WIDTH-1:0]    fall_q;
  logic                chg_q;

  // With PRESCALE=1 the count never leaves 0, so tick stays high.
  assign tick = (pcnt == PLAST);

  // Two-stage synchroniser for the raw pin levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.switch_in;
      s2 <= s1;
    end
  end

  // Shared prescaler, wraps after PRESCALE-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Saturating up/down integrators, stepped only on tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= MID;
      end
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] && cnt[i] != MAX) begin
          cnt[i] <= cnt[i] + CNT_BITS'(1);
        end else if (!s2[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_BITS'(1);
        end
      end
    end
  end

  // Hysteresis: output only moves when the counter hits a rail.
  always_comb begin
    out_nxt = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt[i] == MAX) begin
        out_nxt[i] = 1'b1;
      end else if (cnt[i] == '0) begin
        out_nxt[i] = 1'b0;
      end
    end
  end

  // Debounced level plus edge pulses aligned with the new level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      out_q  <= out_nxt;
      rise_q <= out_nxt & ~out_q;
      fall_q <= ~out_nxt & out_q;
    end
  end

  // Sticky change flag; a fresh edge beats a same-cycle ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chg_q <= 1'b0;
    end else if (|rise_q || |fall_q) begin
      chg_q <= 1'b1;
    end else if (bus.change_ack) begin
      chg_q <= 1'b0;
    end
  end

  assign bus.switch_out = out_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.changed    = chg_q;
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Parametrised successor to the fixed 8-switch filter.
- Debounces WIDTH asynchronous switch or button inputs. Each channel has a 2-flop synchroniser, a prescaled saturating up/down integrator and hysteresis output logic.
- Adds per-channel rise/fall pulses and a sticky change flag with an acknowledge handshake, so the CPU-side GPIO/interrupt logic can poll or interrupt on switch activity.
- Sits between board pins and the memory-mapped switch register.

Parameters:
- WIDTH, 8: number of independent channels.
- CNT_BITS, 6: integrator width. MAX = 2^CNT_BITS-1; MID = 2^(CNT_BITS-1).
- PRESCALE, 1: integrator update period in clock cycles. Legal range 1..65535; 1 means update every cycle.

Ports:
- clock  in  1  single system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- switch_in  in  WIDTH  raw, unsynchronised switch levels.
- switch_out  out  WIDTH  debounced levels.
- rise  out  WIDTH  one-cycle pulse when switch_out[i] goes 0->1.
- fall  out  WIDTH  one-cycle pulse when switch_out[i] goes 1->0.
- changed  out  1  sticky flag: some switch_out bit changed since the last ack.
- change_ack  in  1  single-cycle clear request for changed.

Behaviour:
- Reset (reset=0, takes effect immediately, without waiting for a clock edge):
  - sync stages = 0
  - prescaler = 0
  - all counters = MID
  - switch_out, rise, fall, changed = 0
- Reset mid-operation discards all integration state. After release, the first clock edge is normal operation.
- Synchroniser: s1 <= switch_in; s2 <= s1. Only s2 feeds the integrator; raw input never reaches other logic.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick=1 in the cycle the count equals PRESCALE-1. For PRESCALE=1, tick is constantly 1. The prescaler is shared by all channels.
- Integrator, per channel i, evaluated on edges where tick=1:
  - s2[i]=1 and c[i]!=MAX: c[i] increments by 1.
  - s2[i]=0 and c[i]!=0: c[i] decrements by 1.
  - Otherwise hold.
  - No wrap-around ever; saturates at 0 and MAX.
  - When tick=0, c[i] holds.
- Output, every edge, from the registered counter:
  - c[i]==MAX: switch_out[i] <= 1.
  - c[i]==0: switch_out[i] <= 0.
  - Otherwise hold (hysteresis).
- Edge pulses:
  - rise[i] and fall[i] are registered, computed from the next-state vs. current value of switch_out[i].
  - They are asserted in the same cycle the new switch_out[i] value first appears, for exactly one cycle.
  - Never both high on the same channel.
- changed:
  - Set on any cycle where any rise or fall bit is 1 (next edge after the event); cleared by change_ack=1.
  - Simultaneous new event and ack: set wins, so changed stays 1.
  - Ack while changed=0 has no effect.
- Latency, PRESCALE=1, from input level change to switch_out update:
  - 2 sync edges + (number of counter steps) integrator edges + 1 output edge.
  - From MID after reset: CNT_BITS=6, constant-1 input gives switch_out=1 on the 34th rising edge after the input is stable.
  - From the opposite saturation: 66 edges.
- Glitch rejection: any pulse shorter than the counter distance to the opposite rail produces no output change.
- Channels are fully independent; WIDTH=1 must work.
- Widths: counter arithmetic is CNT_BITS wide with no carry out; prescaler width is ceil(log2(PRESCALE)) with a minimum of 1.

Test Plan:
- Reset/startup: WIDTH=8, CNT_BITS=6, PRESCALE=1. Hold reset=0, then release with switch_in=8'h00. Expect outputs 0 throughout. counter0 reaches 0 after 34 edges; switch_out stays 0; no fall pulse; changed stays 0.
- Clean press: from steady 0 (all counters 0), set switch_in[3]=1. Expect switch_out[3]=1 on the 66th edge, rise[3]=1 for exactly that one cycle, and changed=1 from the next cycle. Other bits unchanged.
- Bounce rejection: from steady 0, toggle switch_in[0] every 5 cycles for 200 cycles, then hold 0. Expect switch_out[0]=0 throughout, with no rise or fall pulses.
- Hysteresis plus release: from steady 1, drive 0 for 40 cycles, then 1 for 40 cycles. Expect switch_out stays 1. Then drive 0 continuously: fall pulse arrives 66 edges after the final 0 is applied, from a counter that had re-saturated at 63.
- Handshake: generate a rise on bit 5, wait 3 cycles, pulse change_ack coincident with a fall event on bit 6. Expect changed stays 1. A second ack with no event clears it to 0.
- Prescale and async reset: PRESCALE=4, from MID drive 1. Expect switch_out=1 within 2+31*4+1 (+up to 3) edges. Asserting reset mid-count drops all outputs to 0 before the next clock edge.
